// File: rtl/l2_request_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l2_request_responder (with l2_pkg)                           |
// | Description : Stand-in for the L2 cache at the far end of the core-to-L2   |
// |               request/response interface. Queues requests in order,        |
// |               tracks synchronized-store reservations and acknowledges each |
// |               request after a fixed pipeline latency. Holds no line data.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef STRANDS_PER_CORE
`define STRANDS_PER_CORE 4
`endif

package l2_pkg;
    localparam int STRAND_W = 2;
    localparam int CORE_W   = 4;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 512;
    localparam int MASK_W   = 64;

    typedef enum logic [1:0] {
        UNIT_ICACHE = 2'd0,
        UNIT_DCACHE = 2'd1,
        UNIT_STBUF  = 2'd2
    } unit_t;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_IINVALIDATE = 3'd3,
        L2REQ_DINVALIDATE = 3'd4,
        L2REQ_LOAD_SYNC   = 3'd5,
        L2REQ_STORE_SYNC  = 3'd6
    } l2req_op_t;

    typedef enum logic [2:0] {
        L2RSP_LOAD_ACK        = 3'd0,
        L2RSP_STORE_ACK       = 3'd1,
        L2RSP_FLUSH_ACK       = 3'd2,
        L2RSP_IINVALIDATE_ACK = 3'd3,
        L2RSP_DINVALIDATE_ACK = 3'd4
    } l2rsp_op_t;

    typedef struct packed {
        logic                valid;
        unit_t               unit;
        logic [STRAND_W-1:0] strand;
        l2req_op_t           op;
        logic [CORE_W-1:0]   core;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic [MASK_W-1:0]   mask;
    } l2req_packet_t;

    typedef struct packed {
        logic                valid;
        logic                status;
        unit_t               unit;
        logic [STRAND_W-1:0] strand;
        l2rsp_op_t           op;
        logic [CORE_W-1:0]   core;
        logic                update;
        logic [1:0]          way;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
    } l2rsp_packet_t;
endpackage

module l2_request_responder
    import l2_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int RESPONSE_LATENCY = 2,
    parameter int NUM_STRANDS      = `STRANDS_PER_CORE
) (
    input  logic          clk,
    input  logic          reset,
    input  l2req_packet_t l2req_packet,
    output logic          l2req_ready,
    output l2rsp_packet_t l2rsp_packet
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (RESPONSE_LATENCY < 1) begin : g_bad_latency
        $error("RESPONSE_LATENCY must be at least 1");
    end

    // Only the fields needed to build the acknowledgement are queued.
    typedef struct packed {
        l2req_op_t           op;
        unit_t               unit;
        logic [STRAND_W-1:0] strand;
        logic [CORE_W-1:0]   core;
        logic [ADDR_W-1:0]   address;
    } fifo_entry_t;

    fifo_entry_t             r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic                    w_push;
    logic                    w_pop;
    fifo_entry_t             w_push_entry;
    fifo_entry_t             w_head;

    logic                    r_res_valid [NUM_STRANDS];
    logic [ADDR_W-1:0]       r_res_addr  [NUM_STRANDS];
    logic [NUM_STRANDS-1:0]  w_addr_match;
    logic                    w_res_hit;

    l2rsp_packet_t           r_pipe [RESPONSE_LATENCY];
    l2rsp_packet_t           w_rsp;

    // Line data and byte mask are never stored; sink them here.
    logic                    w_unused;
    assign w_unused = ^{l2req_packet.data, l2req_packet.mask};

    // Ready depends only on the registered count: no pass-through when full.
    assign l2req_ready = (r_count < c_depth);
    assign w_push      = l2req_packet.valid && l2req_ready;
    assign w_pop       = (r_count != '0);
    assign w_head      = r_fifo[r_rd_ptr];

    assign w_push_entry = '{
        op:      l2req_packet.op,
        unit:    l2req_packet.unit,
        strand:  l2req_packet.strand,
        core:    l2req_packet.core,
        address: l2req_packet.address
    };

    // FIFO storage needs no reset: occupancy is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reservation lookups for the head entry: every matching strand, and the requester's own.
    always_comb begin
        w_addr_match = '0;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            w_addr_match[i] = r_res_valid[i] && (r_res_addr[i] == w_head.address);
        end
        w_res_hit = r_res_valid[w_head.strand] && (r_res_addr[w_head.strand] == w_head.address);
    end

    // Build the acknowledgement for the entry being popped; all-zero when nothing pops.
    always_comb begin
        w_rsp = '0;
        if (w_pop) begin
            w_rsp.valid   = 1'b1;
            w_rsp.status  = 1'b1;
            w_rsp.unit    = w_head.unit;
            w_rsp.strand  = w_head.strand;
            w_rsp.core    = w_head.core;
            w_rsp.address = w_head.address;
            case (w_head.op)
                L2REQ_LOAD, L2REQ_LOAD_SYNC: w_rsp.op = L2RSP_LOAD_ACK;
                L2REQ_STORE:                 w_rsp.op = L2RSP_STORE_ACK;
                L2REQ_STORE_SYNC: begin
                    w_rsp.op     = L2RSP_STORE_ACK;
                    w_rsp.status = w_res_hit;
                end
                L2REQ_FLUSH:                 w_rsp.op = L2RSP_FLUSH_ACK;
                L2REQ_IINVALIDATE:           w_rsp.op = L2RSP_IINVALIDATE_ACK;
                L2REQ_DINVALIDATE:           w_rsp.op = L2RSP_DINVALIDATE_ACK;
                default:                     w_rsp.op = L2RSP_LOAD_ACK;
            endcase
        end
    end

    // Reservation table, updated in program order as each entry pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STRANDS; i++) begin
                r_res_valid[i] <= 1'b0;
                r_res_addr[i]  <= '0;
            end
        end else if (w_pop) begin
            case (w_head.op)
                L2REQ_LOAD_SYNC: begin
                    r_res_valid[w_head.strand] <= 1'b1;
                    r_res_addr[w_head.strand]  <= w_head.address;
                end
                L2REQ_STORE: begin
                    for (int i = 0; i < NUM_STRANDS; i++) begin
                        if (w_addr_match[i]) begin
                            r_res_valid[i] <= 1'b0;
                        end
                    end
                end
                L2REQ_STORE_SYNC: begin
                    // A failed synchronized store leaves every reservation intact.
                    if (w_res_hit) begin
                        for (int i = 0; i < NUM_STRANDS; i++) begin
                            if (w_addr_match[i]) begin
                                r_res_valid[i] <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Fixed-latency response pipeline; invalid stages carry all-zero packets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RESPONSE_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rsp;
            for (int i = 1; i < RESPONSE_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign l2rsp_packet = r_pipe[RESPONSE_LATENCY-1];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && (r_count == c_depth)) && (r_count <= c_depth));

    a_valid_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(l2req_packet.valid));

endmodule
`default_nettype wire

// File: tb/tb_l2_request_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_l2_request_responder                                      |
// | Description : Scoreboard bench for l2_request_responder. Directed requests |
// |               push hand-computed acknowledgements; a monitor pops and      |
// |               compares every response the DUT presents.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_l2_request_responder;
    import l2_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    l2req_packet_t req;
    logic          ready;
    l2rsp_packet_t rsp;

    l2rsp_packet_t exp_q[$];
    int            rsp_cyc[$];
    int            checks = 0;
    int            passed = 0;
    int            cyc = 0;

    l2_request_responder #(
        .FIFO_DEPTH       (4),
        .RESPONSE_LATENCY (2),
        .NUM_STRANDS      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .l2req_packet (req),
        .l2req_ready  (ready),
        .l2rsp_packet (rsp)
    );

    // Clock and a count of completed rising edges.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want)
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        else
            passed++;
    endtask

    // Monitor: every output cycle is compared against the scoreboard or against idle zeros.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp.valid === 1'b1) begin
                rsp_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rsp: got op=%0d strand=%0d addr=%0h expected no response",
                             rsp.op, rsp.strand, rsp.address);
                end else begin
                    l2rsp_packet_t e;
                    e = exp_q.pop_front();
                    if (rsp !== e)
                        $display("FAIL rsp_cmp: got st=%0b op=%0d unit=%0d strand=%0d core=%0h addr=%0h data_nz=%0b expected st=%0b op=%0d unit=%0d strand=%0d core=%0h addr=%0h",
                                 rsp.status, rsp.op, rsp.unit, rsp.strand, rsp.core, rsp.address, |rsp.data,
                                 e.status, e.op, e.unit, e.strand, e.core, e.address);
                    else
                        passed++;
                end
            end else begin
                checks++;
                if (rsp !== '0)
                    $display("FAIL idle_zero: got nonzero idle packet (valid=%b) expected all zero", rsp.valid);
                else
                    passed++;
            end
        end
    end

    function automatic l2rsp_packet_t mk_exp(input l2req_op_t op, input logic [1:0] strand,
                                             input logic [25:0] addr, input logic status);
        l2rsp_packet_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.status  = status;
        e.unit    = (op == L2REQ_STORE || op == L2REQ_STORE_SYNC) ? UNIT_STBUF : UNIT_DCACHE;
        e.strand  = strand;
        e.core    = 4'h5;
        e.address = addr;
        case (op)
            L2REQ_STORE, L2REQ_STORE_SYNC: e.op = L2RSP_STORE_ACK;
            L2REQ_FLUSH:                   e.op = L2RSP_FLUSH_ACK;
            L2REQ_IINVALIDATE:             e.op = L2RSP_IINVALIDATE_ACK;
            L2REQ_DINVALIDATE:             e.op = L2RSP_DINVALIDATE_ACK;
            default:                       e.op = L2RSP_LOAD_ACK;
        endcase
        return e;
    endfunction

    // Present one request from the falling edge; returns the cycle in which it was accepted.
    task automatic send(input l2req_op_t op, input logic [1:0] strand, input logic [25:0] addr,
                        input logic exp_status, output int acc_cyc);
        acc_cyc     = -1;
        @(negedge clk);
        req         = '0;
        req.valid   = 1'b1;
        req.op      = op;
        req.unit    = (op == L2REQ_STORE || op == L2REQ_STORE_SYNC) ? UNIT_STBUF : UNIT_DCACHE;
        req.strand  = strand;
        req.core    = 4'h5;
        req.address = addr;
        req.data    = {16{32'hdeadbeef}};
        req.mask    = '1;
        for (int w = 0; w < 50; w++) begin
            if (w > 0) @(negedge clk);
            if (ready === 1'b1) begin
                acc_cyc = cyc;
                exp_q.push_back(mk_exp(op, strand, addr, exp_status));
                @(posedge clk);
                return;
            end
            @(posedge clk);
        end
        checks++;
        $display("FAIL accept_timeout: got ready=%b expected 1 within 50 cycles", ready);
    endtask

    task automatic idle();
        @(negedge clk);
        req.valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then a few idle cycles to catch extra responses.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int a;
        int acc[6];
        int base;

        req = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_rsp_zero", 64'(rsp !== '0), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(ready), 64'd1);

        // Single store: exact latency of three cycles.
        send(L2REQ_STORE, 2'd2, 26'h10, 1'b1, a);
        idle();
        drain();
        chk("store_latency", 64'(rsp_cyc[$] - a), 64'd3);

        // Synchronized pair, then a repeat without a fresh reservation.
        send(L2REQ_LOAD_SYNC,  2'd1, 26'h40, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd1, 26'h40, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd1, 26'h40, 1'b0, a);
        idle();
        drain();

        // Another strand's store kills the reservation; a different address does not.
        send(L2REQ_LOAD_SYNC,  2'd0, 26'h80, 1'b1, a);
        send(L2REQ_STORE,      2'd3, 26'h80, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd0, 26'h80, 1'b0, a);
        send(L2REQ_LOAD_SYNC,  2'd0, 26'h80, 1'b1, a);
        send(L2REQ_STORE,      2'd3, 26'h84, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd0, 26'h80, 1'b1, a);
        idle();
        drain();

        // Failed sync store keeps the table; successful one kills other matching strands.
        send(L2REQ_LOAD_SYNC,  2'd2, 26'h100, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd2, 26'h104, 1'b0, a);
        send(L2REQ_STORE_SYNC, 2'd2, 26'h100, 1'b1, a);
        send(L2REQ_LOAD_SYNC,  2'd0, 26'h200, 1'b1, a);
        send(L2REQ_LOAD_SYNC,  2'd1, 26'h200, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd0, 26'h200, 1'b1, a);
        send(L2REQ_STORE_SYNC, 2'd1, 26'h200, 1'b0, a);
        idle();
        drain();

        // Six back-to-back requests: accepted every cycle, answered every cycle in order.
        base = rsp_cyc.size();
        for (int i = 0; i < 6; i++)
            send(L2REQ_LOAD, 2'(i), 26'(32'h300 + i * 8), 1'b1, acc[i]);
        idle();
        drain();
        for (int i = 1; i < 6; i++)
            chk("burst_accept_cycle", 64'(acc[i] - acc[0]), 64'(i));
        chk("burst_first_latency", 64'(rsp_cyc[base] - acc[0]), 64'd3);
        for (int i = 1; i < 6; i++)
            chk("burst_rsp_cycle", 64'(rsp_cyc[base + i] - rsp_cyc[base]), 64'(i));

        // Twenty consecutive requests across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            l2req_op_t op;
            case (i % 4)
                0:       op = L2REQ_LOAD;
                1:       op = L2REQ_FLUSH;
                2:       op = L2REQ_IINVALIDATE;
                default: op = L2REQ_DINVALIDATE;
            endcase
            send(op, 2'(i), 26'(32'h1000 + i * 4), 1'b1, a);
        end
        idle();
        drain();

        // Reset with requests queued and in flight: nothing may come back, reservations cleared.
        send(L2REQ_LOAD_SYNC, 2'd1, 26'h40, 1'b1, a);
        send(L2REQ_LOAD,      2'd2, 26'h50, 1'b1, a);
        send(L2REQ_LOAD,      2'd3, 26'h60, 1'b1, a);
        #1;
        reset     = 1'b1;
        req.valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midreset_rsp_zero", 64'(rsp !== '0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_ready", 64'(ready), 64'd1);
        repeat (6) @(negedge clk);
        send(L2REQ_STORE_SYNC, 2'd1, 26'h40, 1'b0, a);
        idle();
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
